// File: rtl/execute_stage.sv
// execute_stage
//   EX stage of the 5-stage MIPS pipeline, fed by the ID/EX register.
//   Forwards operands, runs the ALU, selects the destination register and
//   computes the branch target. Results and the MEM/WB control bits are
//   captured in the EX/MEM register, which supports stall (hold) and flush
//   (bubble).
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stallM, flushM        EX/MEM hold / bubble controls (flush wins)
//   rd1E, rd2E            register-file operands from ID/EX
//   RtE, RdE              rt / rd specifiers
//   signimmE, pcplus4E    sign-extended immediate, PC+4
//   regwriteE, memtoregE, memwriteE, branchE   control bits passed to MEM
//   alucontrolE           ALU operation select
//   alusrcE, regdstE      SrcB and destination-register selects
//   forwardAE, forwardBE  operand forwarding selects
//   resultW               writeback result (forwarding source)
//   regwriteM, memtoregM, memwriteM, branchM, zeroM   registered control/flag
//   aluoutM, writedataM, writeregM, pcbranchM         registered data

module execute_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stallM,
  input  logic               flushM,
  input  logic [WIDTH-1:0]   rd1E,
  input  logic [WIDTH-1:0]   rd2E,
  input  logic [REGBITS-1:0] RtE,
  input  logic [REGBITS-1:0] RdE,
  input  logic [WIDTH-1:0]   signimmE,
  input  logic [WIDTH-1:0]   pcplus4E,
  input  logic               regwriteE,
  input  logic               memtoregE,
  input  logic               memwriteE,
  input  logic               branchE,
  input  logic [2:0]         alucontrolE,
  input  logic               alusrcE,
  input  logic               regdstE,
  input  logic [1:0]         forwardAE,
  input  logic [1:0]         forwardBE,
  input  logic [WIDTH-1:0]   resultW,
  output logic               regwriteM,
  output logic               memtoregM,
  output logic               memwriteM,
  output logic               branchM,
  output logic               zeroM,
  output logic [WIDTH-1:0]   aluoutM,
  output logic [WIDTH-1:0]   writedataM,
  output logic [REGBITS-1:0] writeregM,
  output logic [WIDTH-1:0]   pcbranchM
);

  logic [WIDTH-1:0]   srca;
  logic [WIDTH-1:0]   writedatae;
  logic [WIDTH-1:0]   srcb;
  logic [WIDTH-1:0]   aluresult;
  logic [WIDTH-1:0]   pcbranche;
  logic [REGBITS-1:0] writerege;

  // Forwarding muxes. The MEM-stage source is our own registered aluoutM,
  // so during a stall the held value is what gets forwarded. Select 11 is
  // unused by the hazard unit and falls back to the register-file value.
  always_comb begin
    srca = rd1E;
    case (forwardAE)
      2'b01:   srca = resultW;
      2'b10:   srca = aluoutM;
      default: srca = rd1E;
    endcase
  end

  always_comb begin
    writedatae = rd2E;
    case (forwardBE)
      2'b01:   writedatae = resultW;
      2'b10:   writedatae = aluoutM;
      default: writedatae = rd2E;
    endcase
  end

  // Store data is always the forwarded B operand; the immediate only ever
  // feeds the ALU.
  assign srcb = alusrcE ? signimmE : writedatae;

  // ALU, WIDTH-bit wrapping arithmetic, no overflow detection.
  always_comb begin
    aluresult = '0;
    case (alucontrolE)
      3'b000: aluresult = srca & srcb;
      3'b001: aluresult = srca | srcb;
      3'b010: aluresult = srca + srcb;
      3'b011: aluresult = '0;
      3'b100: aluresult = srca & ~srcb;
      3'b101: aluresult = srca | ~srcb;
      3'b110: aluresult = srca - srcb;
      3'b111: aluresult = ($signed(srca) < $signed(srcb)) ?
                          {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default: aluresult = '0;
    endcase
  end

  // Word-offset branch target; the shifted-out immediate bits are dropped.
  assign pcbranche = pcplus4E + {signimmE[WIDTH-3:0], 2'b00};
  assign writerege = regdstE ? RdE : RtE;

  // EX/MEM register. Reset and flush both insert an all-zero bubble; a
  // flush also overrides a simultaneous stall.
  always_ff @(posedge clk) begin
    if (reset || flushM) begin
      regwriteM  <= 1'b0;
      memtoregM  <= 1'b0;
      memwriteM  <= 1'b0;
      branchM    <= 1'b0;
      zeroM      <= 1'b0;
      aluoutM    <= '0;
      writedataM <= '0;
      writeregM  <= '0;
      pcbranchM  <= '0;
    end else if (!stallM) begin
      regwriteM  <= regwriteE;
      memtoregM  <= memtoregE;
      memwriteM  <= memwriteE;
      branchM    <= branchE;
      zeroM      <= (aluresult == '0);
      aluoutM    <= aluresult;
      writedataM <= writedatae;
      writeregM  <= writerege;
      pcbranchM  <= pcbranche;
    end
  end

endmodule
